// File: rtl/control_sequencer.sv
// Hardwired control unit: fetch, decode IR[31:27], step T0..T7 and drive
// datapath/select_encode strobes. Outputs are decoded from the registered
// state and the current opcode, so each strobe is stable for a whole state.
module control_sequencer #(
  parameter int         OP_W     = 5,
  parameter logic [4:0] ALU_ADD  = 5'b00011,
  parameter int         MEM_WAIT = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] IR,
  input  logic        CON_FF,
  input  logic        stop,
  output logic        PCout,
  output logic        PCin,
  output logic        IncPC,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Read,
  output logic        Write,
  output logic        Yin,
  output logic        Zin,
  output logic        Zlowout,
  output logic        Cout,
  output logic        HIout,
  output logic        LOout,
  output logic        CONin,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic [4:0]  alu_op,
  output logic        Run,
  output logic        Clear
);

  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_PAUSE, S_HALT
  } state_e;

  typedef enum logic [4:0] {
    OP_LD   = 5'b00000, OP_LDI  = 5'b00001, OP_ST   = 5'b00010,
    OP_ADD  = 5'b00011, OP_SUB  = 5'b00100, OP_AND  = 5'b00101,
    OP_OR   = 5'b00110, OP_ADDI = 5'b01100, OP_ANDI = 5'b01101,
    OP_ORI  = 5'b01110, OP_BR   = 5'b10010, OP_JR   = 5'b10011,
    OP_MFHI = 5'b10111, OP_MFLO = 5'b11000, OP_NOP  = 5'b11010,
    OP_HALT = 5'b11011
  } op_e;

  typedef enum logic [3:0] {
    C_NOP, C_ALU, C_IMM, C_LDI, C_LD, C_ST, C_BR, C_JR, C_MFHI, C_MFLO, C_HALT
  } cls_e;

  localparam logic [1:0] WAIT_N = MEM_WAIT[1:0];

  state_e          state_q, state_d;
  logic [1:0]      wait_q, wait_d;
  logic [OP_W-1:0] opc;
  cls_e            cls;
  logic [4:0]      imm_op;
  logic            mem_state, hold, last;
  logic            unused_ir;

  assign opc       = IR[31 -: OP_W];
  assign unused_ir = ^IR[31-OP_W:0];

  // Opcode classification; unlisted opcodes fall through to nop
  always_comb begin
    cls    = C_NOP;
    imm_op = '0;
    case (opc)
      OP_LD:                        cls = C_LD;
      OP_LDI:                       cls = C_LDI;
      OP_ST:                        cls = C_ST;
      OP_ADD, OP_SUB, OP_AND, OP_OR: cls = C_ALU;
      OP_ADDI: begin cls = C_IMM; imm_op = OP_ADD; end
      OP_ANDI: begin cls = C_IMM; imm_op = OP_AND; end
      OP_ORI:  begin cls = C_IMM; imm_op = OP_OR;  end
      OP_BR:                        cls = C_BR;
      OP_JR:                        cls = C_JR;
      OP_MFHI:                      cls = C_MFHI;
      OP_MFLO:                      cls = C_MFLO;
      OP_HALT:                      cls = C_HALT;
      default:                      cls = C_NOP;
    endcase
  end

  // Memory-access states are stretched by MEM_WAIT; last step ends the instruction
  always_comb begin
    mem_state = (state_q == S_T1) ||
                (state_q == S_T6 && cls == C_LD) ||
                (state_q == S_T7 && cls == C_ST);
    hold = mem_state && (wait_q != WAIT_N);
    case (cls)
      C_ALU, C_IMM, C_LDI:   last = (state_q == S_T5);
      C_LD, C_ST:            last = (state_q == S_T7);
      C_BR:                  last = (state_q == S_T6);
      C_JR, C_MFHI, C_MFLO:  last = (state_q == S_T3);
      default:               last = (state_q == S_T2);
    endcase
  end

  // Next-state selection; the wait counter clears whenever the state advances
  always_comb begin
    state_d = state_q;
    wait_d  = '0;
    if (hold) begin
      wait_d = wait_q + 2'd1;
    end else begin
      case (state_q)
        S_RST:   state_d = S_T0;
        S_T0:    state_d = S_T1;
        S_PAUSE: state_d = stop ? S_PAUSE : S_T0;
        S_HALT:  state_d = S_HALT;
        default: begin
          if (state_q == S_T2 && cls == C_HALT) state_d = S_HALT;
          else if (last)                         state_d = stop ? S_PAUSE : S_T0;
          else                                   state_d = state_e'(state_q + 4'd1);
        end
      endcase
    end
  end

  // State and wait-counter registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_RST;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Strobe decode from state and opcode class
  always_comb begin
    {PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Read, Write} = '0;
    {Yin, Zin, Zlowout, Cout, HIout, LOout, CONin}                = '0;
    {Gra, Grb, Grc, Rin, Rout, BAout}                             = '0;
    alu_op = '0;
    Run    = !(state_q == S_RST || state_q == S_PAUSE || state_q == S_HALT);
    Clear  = (state_q == S_RST);
    case (state_q)
      S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; alu_op = ALU_ADD; end
      S_T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
      S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
      S_T3: case (cls)
        C_ALU, C_IMM:      begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
        C_LDI, C_LD, C_ST: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
        C_BR:              begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
        C_JR:              begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
        C_MFHI:            begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
        C_MFLO:            begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
        default: ;
      endcase
      S_T4: case (cls)
        C_ALU:             begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = 5'(opc); end
        C_IMM:             begin Cout = 1'b1; Zin = 1'b1; alu_op = imm_op; end
        C_LDI, C_LD, C_ST: begin Cout = 1'b1; Zin = 1'b1; alu_op = ALU_ADD; end
        C_BR:              begin PCout = 1'b1; Yin = 1'b1; end
        default: ;
      endcase
      S_T5: case (cls)
        C_ALU, C_IMM, C_LDI: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
        C_LD, C_ST:          begin Zlowout = 1'b1; MARin = 1'b1; end
        C_BR:                begin Cout = 1'b1; Zin = 1'b1; alu_op = ALU_ADD; end
        default: ;
      endcase
      S_T6: case (cls)
        C_LD: begin Read = 1'b1; MDRin = 1'b1; end
        C_ST: begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
        C_BR: begin Zlowout = CON_FF; PCin = CON_FF; end
        default: ;
      endcase
      S_T7: case (cls)
        C_LD: begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
        C_ST: Write = 1'b1;
        default: ;
      endcase
      default: ;
    endcase
  end

endmodule
